maze_generator: RTL and testbench
=================================

# maze_generator

Builds a random, perfect maze into the 16×16 `path_data` bitmap consumed by the maze renderer. It is the writer of that bitmap: bit `x + 16*y` is 1 for a path tile and 0 for a wall.
- Generation is a randomized depth-first search over cells at even tile coordinates, carving the odd wall tile between neighbouring cells.
- The block sits between the game-control FSM (start, seed, dimensions) and the renderer.

## Interface
Parameters:
- `GRID` = 16: tile grid dimension; fixed by the renderer's 256-bit bitmap.
- `DEFAULT_SEED` = 16'hACE1: substituted when `seed` is 0.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low (0 = reset)
- `start`  in  1  begin generation; sampled only in IDLE or DONE
- `seed`  in  16  LFSR seed, latched on accepted `start`
- `maze_width`  in  7  maze width in tiles, latched on accepted `start`
- `maze_height`  in  7  maze height in tiles, latched on accepted `start`
- `path_data`  out  256  tile bitmap, bit `x+16*y`; live during generation
- `busy`  out  1  high from the edge accepting `start` until DONE
- `done`  out  1  high in DONE; held until the next accepted `start`

## Operation
- Effective width `w` = clamp(`maze_width`, 1, 15); effective height `h` = clamp(`maze_height`, 1, 15). Values of 0 become 1; values of 16 or more become 15.
- Cells are the tiles with even x < w and even y < h.
  - `cw` = (w+1)/2 and `ch` = (h+1)/2, each ≤ 8.
  - N = `cw`·`ch`, at most 64.
- A cell is visited when its `path_data` bit is 1.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It steps every cycle while `busy`.
- Directions: 0 = N (y−2), 1 = E (x+2), 2 = S (y+2), 3 = W (x−2).
- Stack: 64 entries × 6 bits (cell column 3b, cell row 3b); `sp` is 7 bits. It cannot overflow.

FSM states:
- IDLE: all outputs at reset values. On `start`: latch inputs and go to CLEAR.
- CLEAR: `path_data` ← 0. Go to INIT.
- INIT: set bit (0,0), push cell (0,0). Go to SCAN.
- SCAN: form a 4-bit candidate mask for the top-of-stack cell. A candidate is an in-bounds, unvisited neighbour.
  - If the mask is empty, go to POP.
  - Otherwise take the first set bit scanning cyclically from direction `lfsr[1:0]`, register the chosen direction, and go to CARVE.
- CARVE: set the wall tile bit and the neighbour cell bit, push the neighbour. Go to SCAN.
- POP: decrement `sp`. If the new `sp` is 0, go to DONE; otherwise go to SCAN.
- DONE: `busy`=0, `done`=1. On `start`: same as IDLE.

Invariants and boundary conditions:
- `start` while `busy` is ignored.
- Tiles with x ≥ w or y ≥ h remain 0.
- With odd w and h, the result holds N cells plus N−1 carved walls, so popcount = 2N−1.
- Reset asserted mid-generation clears all outputs, `sp` and state immediately. No partial bitmap survives.

## Timing
- Reset values: `path_data`=0, `busy`=0, `done`=0, state IDLE, `sp`=0, LFSR=`DEFAULT_SEED`.
- Let the edge that accepts `start` be edge 0.
  - `busy` is 1 after edge 0.
  - `path_data` is 0 after edge 1.
  - `done`=1 and `busy`=0 exactly after edge 4N, i.e. 2 + 2(N−1) + 2N cycles.
- Each carve or pop costs 2 cycles: SCAN plus CARVE or POP.
- `path_data` updates only on CLEAR, INIT and CARVE edges.
- Output is deterministic: the same seed and dimensions give an identical bitmap and identical cycle count.

## Structure
- Shared package `maze_pkg` holds:
  - the `GRID` constant;
  - the direction encoding;
  - the FSM state typedef;
  - the LFSR tap mask and `DEFAULT_SEED`;
  - the `tile_index(x,y)` function, which the renderer uses too.
- Sub-module `maze_stack`: 64×6 LIFO with push, pop, top and `sp`. It has no empty or full handshake; the FSM guarantees correct use.

## Test plan
- Reset: hold `reset`=0 for 3 cycles → `path_data`=0, `busy`=0, `done`=0; `start` during reset is ignored.
- 1×1 maze, `seed`=1: `start` → `done` after edge 4, `path_data` has only bit 0 set.
- 3×1 maze: `start` → `done` after edge 8, `path_data` bits {0,1,2} set, all others 0.
- 15×15 maze, `seed`=16'h1234:
  - `done` after edge 256;
  - popcount = 127;
  - all 64 even-even cells set;
  - no bit with x=15 or y=15;
  - scoreboard flood fill from (0,0) reaches all 127 set tiles with no cycles.
- Determinism:
  - the same seed run twice gives identical bitmaps;
  - `seed`=0 matches `seed`=16'hACE1;
  - `seed`=16'h0001 versus 16'h0002 gives differing bitmaps.
- Abort and guard:
  - pulse `start` at cycle 50 → no effect;
  - assert `reset` at cycle 100 → outputs 0 the same cycle;
  - a fresh `start` afterwards completes normally in 4N cycles.

Source files
------------

// File: rtl/maze_pkg.sv
// maze_pkg: constants, encodings and bitmap indexing shared by the maze
// generator and the renderer.
package maze_pkg;
    localparam int GRID = 16;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {DIR_N, DIR_E, DIR_S, DIR_W} dir_t;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_INIT, S_SCAN, S_CARVE, S_POP, S_DONE
    } state_t;

    typedef struct packed {
        logic [2:0] row;
        logic [2:0] col;
    } cell_t;

    function automatic logic [7:0] tile_index(input logic [3:0] x, input logic [3:0] y);
        return {y, x};
    endfunction

    function automatic logic [3:0] clamp_dim(input logic [6:0] v);
        return v == 7'd0 ? 4'd1 : v >= 7'd15 ? 4'd15 : v[3:0];
    endfunction
endpackage

// File: rtl/maze_stack.sv
// maze_stack: 64-entry LIFO of cell coordinates; the caller never pops empty
// or pushes full.
module maze_stack
    import maze_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  cell_t       din,
    output cell_t       top,
    output logic [6:0]  sp
);
    cell_t mem [64];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sp <= '0;
        else if (push) sp <= sp + 7'd1;
        else if (pop) sp <= sp - 7'd1;
    end

    always_ff @(posedge clk) begin
        if (push) mem[sp[5:0]] <= din;
    end

    assign top = mem[6'(sp - 7'd1)];
endmodule

// File: rtl/maze_generator.sv
// maze_generator: randomized depth-first search carving a perfect maze into
// the 16x16 path bitmap (bit x+16*y, 1 = path).
module maze_generator #(
    parameter int          GRID         = maze_pkg::GRID,
    parameter logic [15:0] DEFAULT_SEED = maze_pkg::DEFAULT_SEED
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [15:0]            seed,
    input  logic [6:0]             maze_width,
    input  logic [6:0]             maze_height,
    output logic [GRID*GRID-1:0]   path_data,
    output logic                   busy,
    output logic                   done
);
    import maze_pkg::*;

    state_t      state, state_nx;
    dir_t        dir, pick;
    cell_t       top, push_cell;
    logic [15:0] lfsr;
    logic [6:0]  sp;
    logic [3:0]  w, h, tx, ty, wx, wy, nx, ny, mask, rot;
    logic [1:0]  off;
    logic        push, pop, accept;

    assign busy   = state != S_IDLE && state != S_DONE;
    assign done   = state == S_DONE;
    assign accept = start && !busy;

    assign tx = {top.col, 1'b0};
    assign ty = {top.row, 1'b0};

    // Candidate neighbours of the top-of-stack cell: in bounds and not yet carved.
    assign mask = {
        tx != 4'd0 && !path_data[tile_index(tx - 4'd2, ty)],
        5'(ty) + 5'd2 < 5'(h) && !path_data[tile_index(tx, ty + 4'd2)],
        5'(tx) + 5'd2 < 5'(w) && !path_data[tile_index(tx + 4'd2, ty)],
        ty != 4'd0 && !path_data[tile_index(tx, ty - 4'd2)]
    };
    assign rot  = 4'({mask, mask} >> lfsr[1:0]);
    assign off  = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    assign pick = dir_t'(lfsr[1:0] + off);

    assign wx = dir == DIR_E ? tx + 4'd1 : dir == DIR_W ? tx - 4'd1 : tx;
    assign nx = dir == DIR_E ? tx + 4'd2 : dir == DIR_W ? tx - 4'd2 : tx;
    assign wy = dir == DIR_S ? ty + 4'd1 : dir == DIR_N ? ty - 4'd1 : ty;
    assign ny = dir == DIR_S ? ty + 4'd2 : dir == DIR_N ? ty - 4'd2 : ty;

    always_comb begin
        state_nx  = state;
        push      = 1'b0;
        pop       = 1'b0;
        push_cell = '0;
        case (state)
            S_IDLE, S_DONE: state_nx = start ? S_CLEAR : state;
            S_CLEAR:        state_nx = S_INIT;
            S_INIT: begin
                push     = 1'b1;
                state_nx = S_SCAN;
            end
            S_SCAN:         state_nx = mask == 4'd0 ? S_POP : S_CARVE;
            S_CARVE: begin
                push      = 1'b1;
                push_cell = '{row: ny[3:1], col: nx[3:1]};
                state_nx  = S_SCAN;
            end
            S_POP: begin
                pop      = 1'b1;
                state_nx = sp == 7'd1 ? S_DONE : S_SCAN;
            end
            default:        state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            path_data <= '0;
            lfsr      <= DEFAULT_SEED;
            w         <= 4'd1;
            h         <= 4'd1;
            dir       <= DIR_N;
        end else begin
            state <= state_nx;
            if (accept) begin
                lfsr <= seed == 16'd0 ? DEFAULT_SEED : seed;
                w    <= clamp_dim(maze_width);
                h    <= clamp_dim(maze_height);
            end else if (busy) begin
                lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
            end
            if (state == S_SCAN) dir <= pick;
            if (state == S_CLEAR) begin
                path_data <= '0;
            end else if (state == S_INIT) begin
                path_data[0] <= 1'b1;
            end else if (state == S_CARVE) begin
                path_data[tile_index(wx, wy)] <= 1'b1;
                path_data[tile_index(nx, ny)] <= 1'b1;
            end
        end
    end

    maze_stack u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (push_cell),
        .top   (top),
        .sp    (sp)
    );
endmodule

// File: tb/tb_maze_generator.sv
// tb_maze_generator: randomized maze runs checked against a graph-level model
// of a perfect maze (cell coverage, tree shape, bounds, timing).
module tb_maze_generator;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [15:0]  seed = '0;
    logic [6:0]   maze_width = '0;
    logic [6:0]   maze_height = '0;
    logic [255:0] path_data;
    logic         busy, done;
    int           total = 0;
    int           bad = 0;

    maze_generator dut (
        .clk(clk), .reset(reset), .start(start), .seed(seed),
        .maze_width(maze_width), .maze_height(maze_height),
        .path_data(path_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int eff(input int v);
        return v < 1 ? 1 : v > 15 ? 15 : v;
    endfunction

    function automatic int n_cells(input int mw, input int mh);
        return ((eff(mw) + 1) / 2) * ((eff(mh) + 1) / 2);
    endfunction

    // Graph view of the bitmap: tiles, adjacencies, flood fill from (0,0).
    function automatic void analyze(input logic [255:0] bm, input int w, input int h,
                                    output int pop, output int reach, output int edges,
                                    output int stray, output int miss);
        bit seen [256];
        int q[$];
        int t, x0, y0, x1, y1;
        pop = 0; reach = 0; edges = 0; stray = 0; miss = 0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                if (bm[x + 16 * y]) begin
                    pop++;
                    if (x >= w || y >= h || (x % 2 == 1 && y % 2 == 1)) stray++;
                    if (x < 15 && bm[x + 1 + 16 * y]) edges++;
                    if (y < 15 && bm[x + 16 * (y + 1)]) edges++;
                end else if (x % 2 == 0 && y % 2 == 0 && x < w && y < h) begin
                    miss++;
                end
        if (bm[0]) begin
            q.push_back(0);
            seen[0] = 1'b1;
        end
        while (q.size() > 0) begin
            t = q.pop_front();
            reach++;
            x0 = t % 16;
            y0 = t / 16;
            for (int d = 0; d < 4; d++) begin
                x1 = x0 + (d == 1 ? 1 : d == 3 ? -1 : 0);
                y1 = y0 + (d == 2 ? 1 : d == 0 ? -1 : 0);
                if (x1 >= 0 && x1 < 16 && y1 >= 0 && y1 < 16 && bm[x1 + 16 * y1] && !seen[x1 + 16 * y1]) begin
                    seen[x1 + 16 * y1] = 1'b1;
                    q.push_back(x1 + 16 * y1);
                end
            end
        end
    endfunction

    // Drives one generation; pulse_at >= 0 re-asserts start before that edge.
    task automatic run_maze(input logic [15:0] s, input logic [6:0] mw, input logic [6:0] mh,
                            input int pulse_at, output logic [255:0] bm, output int cyc,
                            output bit busy_ok, output bit clr_ok, output bit end_ok);
        @(negedge clk);
        seed = s; maze_width = mw; maze_height = mh; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        busy_ok = busy === 1'b1 && done === 1'b0;
        clr_ok = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 1000) begin
            if (cyc == pulse_at) begin
                start = 1'b1; seed = ~s; maze_width = 7'd3; maze_height = 7'd3;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = 1'b0;
            if (cyc == 1) clr_ok = path_data === '0;
        end
        end_ok = busy === 1'b0;
        bm = path_data;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; maze_width = 7'd5; maze_height = 7'd5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (path_data !== '0) begin bad++; $display("FAIL reset_path: got %h want 0", path_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        start = 1'b0; reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_start_ignored: busy=%b want 0", busy); end
    endtask

    task automatic test_small();
        logic [255:0] bm;
        int cyc;
        bit b_ok, c_ok, e_ok;
        run_maze(16'h0001, 7'd1, 7'd1, -1, bm, cyc, b_ok, c_ok, e_ok);
        total++; if (!b_ok) begin bad++; $display("FAIL m1x1_busy: busy not set after accepting edge"); end
        total++; if (cyc != 4) begin bad++; $display("FAIL m1x1_cycles: got %0d want 4", cyc); end
        total++; if (bm !== 256'h1) begin bad++; $display("FAIL m1x1_bitmap: got %h want 1", bm); end
        total++; if (!e_ok) begin bad++; $display("FAIL m1x1_busy_end: busy still high at done"); end
        run_maze(16'h0077, 7'd3, 7'd1, -1, bm, cyc, b_ok, c_ok, e_ok);
        total++; if (cyc != 8) begin bad++; $display("FAIL m3x1_cycles: got %0d want 8", cyc); end
        total++; if (bm !== 256'h7) begin bad++; $display("FAIL m3x1_bitmap: got %h want 7", bm); end
        total++; if (!c_ok) begin bad++; $display("FAIL m3x1_clear: previous bitmap survived clear"); end
    endtask

    task automatic test_full();
        logic [255:0] bm;
        int cyc, pop, reach, edges, stray, miss;
        bit b_ok, c_ok, e_ok;
        run_maze(16'h1234, 7'd15, 7'd15, -1, bm, cyc, b_ok, c_ok, e_ok);
        analyze(bm, 15, 15, pop, reach, edges, stray, miss);
        total++; if (cyc != 256) begin bad++; $display("FAIL full_cycles: got %0d want 256", cyc); end
        total++; if (pop != 127) begin bad++; $display("FAIL full_popcount: got %0d want 127", pop); end
        total++; if (miss != 0) begin bad++; $display("FAIL full_cells: %0d cells missing want 0", miss); end
        total++; if (stray != 0) begin bad++; $display("FAIL full_bounds: %0d stray tiles want 0", stray); end
        total++; if (reach != 127) begin bad++; $display("FAIL full_reach: got %0d want 127", reach); end
        total++; if (edges != 126) begin bad++; $display("FAIL full_tree: got %0d adjacencies want 126", edges); end
    endtask

    task automatic test_determinism();
        logic [255:0] a, b;
        int ca, cb;
        bit b_ok, c_ok, e_ok;
        run_maze(16'h5A5A, 7'd9, 7'd11, -1, a, ca, b_ok, c_ok, e_ok);
        run_maze(16'h5A5A, 7'd9, 7'd11, -1, b, cb, b_ok, c_ok, e_ok);
        total++; if (a !== b) begin bad++; $display("FAIL det_repeat: got %h want %h", b, a); end
        total++; if (ca != cb) begin bad++; $display("FAIL det_cycles: got %0d want %0d", cb, ca); end
        run_maze(16'h0000, 7'd15, 7'd15, -1, a, ca, b_ok, c_ok, e_ok);
        run_maze(16'hACE1, 7'd15, 7'd15, -1, b, cb, b_ok, c_ok, e_ok);
        total++; if (a !== b) begin bad++; $display("FAIL det_zero_seed: got %h want %h", a, b); end
        run_maze(16'h0001, 7'd15, 7'd15, -1, a, ca, b_ok, c_ok, e_ok);
        run_maze(16'h0002, 7'd15, 7'd15, -1, b, cb, b_ok, c_ok, e_ok);
        total++; if (a === b) begin bad++; $display("FAIL det_seed_differs: both seeds gave %h want differing", a); end
    endtask

    task automatic test_random();
        logic [255:0] bm;
        logic [6:0] mw, mh;
        int cyc, pop, reach, edges, stray, miss, n;
        bit b_ok, c_ok, e_ok;
        for (int i = 0; i < 10; i++) begin
            mw = 7'($urandom_range(0, 20));
            mh = 7'($urandom_range(0, 20));
            n = n_cells(mw, mh);
            run_maze(16'($urandom), mw, mh, -1, bm, cyc, b_ok, c_ok, e_ok);
            analyze(bm, eff(mw), eff(mh), pop, reach, edges, stray, miss);
            total++; if (!(b_ok && c_ok && e_ok)) begin bad++; $display("FAIL rnd%0d_flags: busy=%b clear=%b end=%b want 111", i, b_ok, c_ok, e_ok); end
            total++; if (cyc != 4 * n) begin bad++; $display("FAIL rnd%0d_cycles %0dx%0d: got %0d want %0d", i, mw, mh, cyc, 4 * n); end
            total++; if (pop != 2 * n - 1) begin bad++; $display("FAIL rnd%0d_popcount: got %0d want %0d", i, pop, 2 * n - 1); end
            total++; if (miss != 0 || stray != 0) begin bad++; $display("FAIL rnd%0d_layout: missing=%0d stray=%0d want 0 0", i, miss, stray); end
            total++; if (reach != pop || edges != pop - 1) begin bad++; $display("FAIL rnd%0d_tree: reach=%0d edges=%0d want %0d %0d", i, reach, edges, pop, pop - 1); end
        end
    endtask

    task automatic test_abort();
        logic [255:0] ref_bm, bm;
        int cr, cyc;
        bit b_ok, c_ok, e_ok;
        run_maze(16'hBEEF, 7'd15, 7'd15, -1, ref_bm, cr, b_ok, c_ok, e_ok);
        run_maze(16'hBEEF, 7'd15, 7'd15, 50, bm, cyc, b_ok, c_ok, e_ok);
        total++; if (cyc != 256) begin bad++; $display("FAIL abort_guard_cycles: got %0d want 256", cyc); end
        total++; if (bm !== ref_bm) begin bad++; $display("FAIL abort_guard_bitmap: got %h want %h", bm, ref_bm); end
        @(negedge clk);
        seed = 16'h4321; maze_width = 7'd15; maze_height = 7'd15; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        total++; if (path_data !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL abort_reset: path=%h busy=%b done=%b want 0 0 0", path_data, busy, done);
        end
        @(negedge clk);
        reset = 1'b1;
        run_maze(16'h0F0F, 7'd5, 7'd7, -1, bm, cyc, b_ok, c_ok, e_ok);
        total++; if (cyc != 48) begin bad++; $display("FAIL abort_restart_cycles: got %0d want 48", cyc); end
        total++; if (!(b_ok && c_ok && e_ok)) begin bad++; $display("FAIL abort_restart_flags: busy=%b clear=%b end=%b want 111", b_ok, c_ok, e_ok); end
    endtask

    initial begin
        test_reset();
        test_small();
        test_full();
        test_determinism();
        test_random();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
